// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access controller: owns MAR/MDR, sequences RAM or device-register
// accesses with a programmable hold time and returns the one-cycle "R" pulse.
module lc3_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mem_req,
  input  logic        mem_rw,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic        ready,
  output logic        busy,
  output logic [15:0] ADDR,
  output logic [15:0] DATAin,
  output logic        R_W,
  output logic        MEM_EN,
  input  logic [15:0] MEMout,
  output logic        io_en,
  input  logic [15:0] io_rdata
);

  // state  | meaning
  // IDLE   | loads accepted, waiting for mem_req
  // ACCESS | strobes asserted, wait counter running
  // DONE   | ready pulse, MDR holds read data
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] mar_next;
  logic        io_hit;

  // The I/O decision must see a MAR loaded on the same edge as the request.
  assign mar_next = ld_mar ? bus_in : mar;
  assign io_hit   = (mar_next >= IO_BASE);

  assign ADDR   = mar;
  assign DATAin = mdr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mar    <= 16'h0000;
      mdr    <= 16'h0000;
      MEM_EN <= 1'b0;
      io_en  <= 1'b0;
      R_W    <= 1'b0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_mar) mar <= bus_in;
          if (ld_mdr) mdr <= bus_in;
          if (mem_req) begin
            cnt    <= CNT_LOAD;
            MEM_EN <= ~io_hit;
            io_en  <= io_hit;
            R_W    <= mem_rw;
            busy   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // R_W and io_en still hold the latched access type here.
            if (!R_W) mdr <= io_en ? io_rdata : MEMout;
            MEM_EN <= 1'b0;
            io_en  <= 1'b0;
            R_W    <= 1'b0;
            ready  <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
